// File: rtl/spu_fx_pkg.sv
// spu_fx_pkg: opcode encodings, internal operation/element types and the opcode decoder
// shared by the SPU fixed-point pipe and its lane ALU.
package spu_fx_pkg;

  localparam logic [10:0] OPC_AH    = 11'b00011001000;
  localparam logic [10:0] OPC_A     = 11'b00011000000;
  localparam logic [10:0] OPC_SFH   = 11'b00001001000;
  localparam logic [10:0] OPC_SF    = 11'b00001000000;
  localparam logic [10:0] OPC_AND   = 11'b00011000001;
  localparam logic [10:0] OPC_ANDC  = 11'b01011000001;
  localparam logic [10:0] OPC_OR    = 11'b00001000001;
  localparam logic [10:0] OPC_ORC   = 11'b01011001001;
  localparam logic [10:0] OPC_XOR   = 11'b01001000001;
  localparam logic [10:0] OPC_NAND  = 11'b00011001001;
  localparam logic [10:0] OPC_NOR   = 11'b00001001001;
  localparam logic [10:0] OPC_CEQH  = 11'b01111001000;
  localparam logic [10:0] OPC_CEQ   = 11'b01111000000;
  localparam logic [10:0] OPC_CGTH  = 11'b01001001000;
  localparam logic [10:0] OPC_CGT   = 11'b01001000000;
  localparam logic [10:0] OPC_CLGTH = 11'b01011001000;
  localparam logic [10:0] OPC_CLGT  = 11'b01011000000;
  localparam logic [10:0] OPC_CLZ   = 11'b01010100101;

  localparam logic [7:0] OPC_AHI   = 8'b00011101;
  localparam logic [7:0] OPC_AI    = 8'b00011100;
  localparam logic [7:0] OPC_SFHI  = 8'b00001101;
  localparam logic [7:0] OPC_SFI   = 8'b00001100;
  localparam logic [7:0] OPC_ANDHI = 8'b00010101;
  localparam logic [7:0] OPC_ANDI  = 8'b00010100;
  localparam logic [7:0] OPC_ORHI  = 8'b00000101;
  localparam logic [7:0] OPC_ORI   = 8'b00000100;
  localparam logic [7:0] OPC_XORHI = 8'b01000101;
  localparam logic [7:0] OPC_XORI  = 8'b01000100;
  localparam logic [7:0] OPC_CEQHI = 8'b01111101;
  localparam logic [7:0] OPC_CEQI  = 8'b01111100;
  localparam logic [7:0] OPC_CGTHI = 8'b01001101;
  localparam logic [7:0] OPC_CGTI  = 8'b01001100;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ANDC, OP_OR, OP_ORC, OP_XOR, OP_NAND, OP_NOR,
    OP_CEQ, OP_CGT, OP_CLGT, OP_CLZ, OP_ILLEGAL
  } fx_op_e;

  typedef enum logic {EM_HALF, EM_WORD} elem_mode_e;

  typedef struct packed {
    fx_op_e     op;
    elem_mode_e mode;
    logic       is_imm;
  } fx_dec_t;

  // RR encodings take priority; only then is the RI10 field in opc[10:3] considered.
  function automatic fx_dec_t fx_decode(input logic [10:0] opc);
    fx_dec_t d;
    d = '{op: OP_ILLEGAL, mode: EM_WORD, is_imm: 1'b0};
    case (opc)
      OPC_AH:    d = '{OP_ADD,  EM_HALF, 1'b0};
      OPC_A:     d = '{OP_ADD,  EM_WORD, 1'b0};
      OPC_SFH:   d = '{OP_SUB,  EM_HALF, 1'b0};
      OPC_SF:    d = '{OP_SUB,  EM_WORD, 1'b0};
      OPC_AND:   d = '{OP_AND,  EM_WORD, 1'b0};
      OPC_ANDC:  d = '{OP_ANDC, EM_WORD, 1'b0};
      OPC_OR:    d = '{OP_OR,   EM_WORD, 1'b0};
      OPC_ORC:   d = '{OP_ORC,  EM_WORD, 1'b0};
      OPC_XOR:   d = '{OP_XOR,  EM_WORD, 1'b0};
      OPC_NAND:  d = '{OP_NAND, EM_WORD, 1'b0};
      OPC_NOR:   d = '{OP_NOR,  EM_WORD, 1'b0};
      OPC_CEQH:  d = '{OP_CEQ,  EM_HALF, 1'b0};
      OPC_CEQ:   d = '{OP_CEQ,  EM_WORD, 1'b0};
      OPC_CGTH:  d = '{OP_CGT,  EM_HALF, 1'b0};
      OPC_CGT:   d = '{OP_CGT,  EM_WORD, 1'b0};
      OPC_CLGTH: d = '{OP_CLGT, EM_HALF, 1'b0};
      OPC_CLGT:  d = '{OP_CLGT, EM_WORD, 1'b0};
      OPC_CLZ:   d = '{OP_CLZ,  EM_WORD, 1'b0};
      default: begin
        case (opc[10:3])
          OPC_AHI:   d = '{OP_ADD, EM_HALF, 1'b1};
          OPC_AI:    d = '{OP_ADD, EM_WORD, 1'b1};
          OPC_SFHI:  d = '{OP_SUB, EM_HALF, 1'b1};
          OPC_SFI:   d = '{OP_SUB, EM_WORD, 1'b1};
          OPC_ANDHI: d = '{OP_AND, EM_HALF, 1'b1};
          OPC_ANDI:  d = '{OP_AND, EM_WORD, 1'b1};
          OPC_ORHI:  d = '{OP_OR,  EM_HALF, 1'b1};
          OPC_ORI:   d = '{OP_OR,  EM_WORD, 1'b1};
          OPC_XORHI: d = '{OP_XOR, EM_HALF, 1'b1};
          OPC_XORI:  d = '{OP_XOR, EM_WORD, 1'b1};
          OPC_CEQHI: d = '{OP_CEQ, EM_HALF, 1'b1};
          OPC_CEQI:  d = '{OP_CEQ, EM_WORD, 1'b1};
          OPC_CGTHI: d = '{OP_CGT, EM_HALF, 1'b1};
          OPC_CGTI:  d = '{OP_CGT, EM_WORD, 1'b1};
          default:   d = '{OP_ILLEGAL, EM_WORD, 1'b0};
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/spu_fx_alu.sv
// spu_fx_alu: combinational SIMD lane ALU over halfword or word elements; no carries cross
// element boundaries.
module spu_fx_alu
  import spu_fx_pkg::*;
#(
  parameter int unsigned DATA_W = 128
) (
  input  fx_op_e            op,
  input  elem_mode_e        mode,
  input  logic [DATA_W-1:0] ra,
  input  logic [DATA_W-1:0] rb_or_imm,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned NumHalf = DATA_W / 16;
  localparam int unsigned NumWord = DATA_W / 32;

  function automatic logic [31:0] lane(input fx_op_e fop, input logic [31:0] a,
                                       input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (fop)
      OP_ADD:  r = a + b;
      OP_SUB:  r = b - a;
      OP_AND:  r = a & b;
      OP_ANDC: r = a & ~b;
      OP_OR:   r = a | b;
      OP_ORC:  r = a | ~b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_CEQ:  r = {32{a == b}};
      OP_CGT:  r = {32{$signed(a) > $signed(b)}};
      OP_CLGT: r = {32{a > b}};
      OP_CLZ: begin
        r = 32'd32;
        for (int i = 0; i < 32; i++) begin
          if (a[i]) r = 32'(31 - i);
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Halfwords ride in the upper half of the 32-bit datapath so that wrap-around and both
  // signed and unsigned ordering behave exactly as on 16-bit values.
  always_comb begin
    result = '0;
    if (mode == EM_HALF) begin
      for (int i = 0; i < int'(NumHalf); i++) begin
        result[i*16 +: 16] = 16'(lane(op, {ra[i*16 +: 16], 16'h0000},
                                     {rb_or_imm[i*16 +: 16], 16'h0000}) >> 16);
      end
    end else begin
      for (int i = 0; i < int'(NumWord); i++) begin
        result[i*32 +: 32] = lane(op, ra[i*32 +: 32], rb_or_imm[i*32 +: 32]);
      end
    end
  end

endmodule

// File: rtl/spu_fx_pipe.sv
// spu_fx_pipe: decode, ALU and LAT-deep writeback pipeline of the SPU even-pipe fixed-point unit.
// Define SPU_FX_FWD_EN to expose live per-stage valid/tag/data for forwarding.
module spu_fx_pipe
  import spu_fx_pkg::*;
#(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned LAT     = 2,
  parameter int unsigned RADDR_W = 7,
  parameter int unsigned OPC_W   = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic                    flush,
  input  logic [OPC_W-1:0]        opcode,
  input  logic [DATA_W-1:0]       ra,
  input  logic [DATA_W-1:0]       rb,
  input  logic [9:0]              imm10,
  input  logic [RADDR_W-1:0]      rt_addr,
  output logic                    wb_valid,
  output logic [RADDR_W-1:0]      wb_rt_addr,
  output logic [DATA_W-1:0]       wb_data,
  output logic                    illegal_op,
  output logic [LAT-1:0]          stage_valid,
  output logic [LAT*RADDR_W-1:0]  stage_rt_addr,
  output logic [LAT*DATA_W-1:0]   stage_data
);

  fx_dec_t           dec;
  logic [DATA_W-1:0] imm_half, imm_word, operand_b, alu_res;
  logic              issue_ok, illegal_d, illegal_q;

  logic [LAT-1:0]     valid_d, valid_q;
  logic [RADDR_W-1:0] tag_d  [LAT];
  logic [RADDR_W-1:0] tag_q  [LAT];
  logic [DATA_W-1:0]  data_d [LAT];
  logic [DATA_W-1:0]  data_q [LAT];

  assign dec       = fx_decode(opcode[10:0]);
  assign imm_half  = {(DATA_W/16){{6{imm10[9]}}, imm10}};
  assign imm_word  = {(DATA_W/32){{22{imm10[9]}}, imm10}};
  assign operand_b = !dec.is_imm ? rb : ((dec.mode == EM_HALF) ? imm_half : imm_word);
  assign issue_ok  = issue_valid && !flush && (dec.op != OP_ILLEGAL);
  assign illegal_d = issue_valid && !flush && (dec.op == OP_ILLEGAL);

  spu_fx_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op        (dec.op),
    .mode      (dec.mode),
    .ra        (ra),
    .rb_or_imm (operand_b),
    .result    (alu_res)
  );

  // Payload registers load only behind a valid entry, so writeback values hold across bubbles
  // and flushes leave data untouched.
  always_comb begin
    valid_d = '0;
    tag_d   = tag_q;
    data_d  = data_q;
    if (issue_ok) begin
      valid_d[0] = 1'b1;
      tag_d[0]   = rt_addr;
      data_d[0]  = alu_res;
    end
    for (int k = 1; k < int'(LAT); k++) begin
      if (valid_q[k-1] && !flush) begin
        valid_d[k] = 1'b1;
        tag_d[k]   = tag_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      illegal_q <= 1'b0;
      for (int k = 0; k < int'(LAT); k++) begin
        tag_q[k]  <= '0;
        data_q[k] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
    end
  end

  assign wb_valid   = valid_q[LAT-1];
  assign wb_rt_addr = tag_q[LAT-1];
  assign wb_data    = data_q[LAT-1];
  assign illegal_op = illegal_q;

`ifdef SPU_FX_FWD_EN
  always_comb begin
    stage_valid   = valid_q;
    stage_rt_addr = '0;
    stage_data    = '0;
    for (int k = 0; k < int'(LAT); k++) begin
      stage_rt_addr[k*RADDR_W +: RADDR_W] = tag_q[k];
      stage_data[k*DATA_W +: DATA_W]      = data_q[k];
    end
  end
`else
  assign stage_valid   = '0;
  assign stage_rt_addr = '0;
  assign stage_data    = '0;
`endif

endmodule

// File: tb/tb_spu_fx_pipe.sv
// tb_spu_fx_pipe: directed stimulus against an element-level reference model; a per-cycle
// compare process checks writeback, illegal_op and the stage ports.
module tb_spu_fx_pipe;

  localparam int unsigned DATA_W  = 128;
  localparam int unsigned LAT     = 2;
  localparam int unsigned RADDR_W = 7;
  localparam int unsigned OPC_W   = 11;

  logic                   clk, reset, issue_valid, flush;
  logic [OPC_W-1:0]       opcode;
  logic [DATA_W-1:0]      ra, rb;
  logic [9:0]             imm10;
  logic [RADDR_W-1:0]     rt_addr;
  logic                   wb_valid, illegal_op;
  logic [RADDR_W-1:0]     wb_rt_addr;
  logic [DATA_W-1:0]      wb_data;
  logic [LAT-1:0]         stage_valid;
  logic [LAT*RADDR_W-1:0] stage_rt_addr;
  logic [LAT*DATA_W-1:0]  stage_data;

  spu_fx_pipe #(
    .DATA_W  (DATA_W),
    .LAT     (LAT),
    .RADDR_W (RADDR_W),
    .OPC_W   (OPC_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .flush         (flush),
    .opcode        (opcode),
    .ra            (ra),
    .rb            (rb),
    .imm10         (imm10),
    .rt_addr       (rt_addr),
    .wb_valid      (wb_valid),
    .wb_rt_addr    (wb_rt_addr),
    .wb_data       (wb_data),
    .illegal_op    (illegal_op),
    .stage_valid   (stage_valid),
    .stage_rt_addr (stage_rt_addr),
    .stage_data    (stage_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ecount   = 0;
  always @(posedge clk) ecount <= ecount + 1;

  typedef struct {
    int           due;
    logic [6:0]   tag;
    logic [127:0] data;
  } wb_t;
  wb_t          exp_q[$];
  bit           rst_at[int];
  bit           ill_at[int];
  logic [127:0] held_data = '0;
  logic [6:0]   held_tag  = '0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, ecount, act, exp);
    end
  endtask

  // Reference: element-wise arithmetic on plain integers, driven by the mnemonic's meaning.
  function automatic logic [127:0] ref_fx(input logic [10:0] opc, input logic [127:0] av,
                                          input logic [127:0] bv, input logic [9:0] im,
                                          output bit legal);
    string k; int w; bit ri; logic [127:0] r, t;
    longint mask, half, x, y, sx, sy, z;
    legal = 1; ri = 0; w = 32; k = ""; r = '0;
    case (opc)
      11'b00011001000: begin k = "add"; w = 16; end
      11'b00011000000: k = "add";
      11'b00001001000: begin k = "sub"; w = 16; end
      11'b00001000000: k = "sub";
      11'b00011000001: k = "and";
      11'b01011000001: k = "andc";
      11'b00001000001: k = "or";
      11'b01011001001: k = "orc";
      11'b01001000001: k = "xor";
      11'b00011001001: k = "nand";
      11'b00001001001: k = "nor";
      11'b01111001000: begin k = "ceq"; w = 16; end
      11'b01111000000: k = "ceq";
      11'b01001001000: begin k = "cgt"; w = 16; end
      11'b01001000000: k = "cgt";
      11'b01011001000: begin k = "clgt"; w = 16; end
      11'b01011000000: k = "clgt";
      11'b01010100101: k = "clz";
      default: begin
        ri = 1;
        case (opc[10:3])
          8'b00011101: begin k = "add"; w = 16; end
          8'b00011100: k = "add";
          8'b00001101: begin k = "sub"; w = 16; end
          8'b00001100: k = "sub";
          8'b00010101: begin k = "and"; w = 16; end
          8'b00010100: k = "and";
          8'b00000101: begin k = "or"; w = 16; end
          8'b00000100: k = "or";
          8'b01000101: begin k = "xor"; w = 16; end
          8'b01000100: k = "xor";
          8'b01111101: begin k = "ceq"; w = 16; end
          8'b01111100: k = "ceq";
          8'b01001101: begin k = "cgt"; w = 16; end
          8'b01001100: k = "cgt";
          default: legal = 0;
        endcase
      end
    endcase
    if (!legal) return '0;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    for (int e = 0; e < 128 / w; e++) begin
      t = av >> (e * w);
      x = longint'(t[31:0]) & mask;
      t = bv >> (e * w);
      y = ri ? (longint'($signed(im)) & mask) : (longint'(t[31:0]) & mask);
      sx = (x >= half) ? x - (mask + 1) : x;
      sy = (y >= half) ? y - (mask + 1) : y;
      case (k)
        "add":  z = (x + y) & mask;
        "sub":  z = (y - x) & mask;
        "and":  z = x & y;
        "andc": z = x & (~y & mask);
        "or":   z = x | y;
        "orc":  z = x | (~y & mask);
        "xor":  z = x ^ y;
        "nand": z = ~(x & y) & mask;
        "nor":  z = ~(x | y) & mask;
        "ceq":  z = (x == y) ? mask : 0;
        "cgt":  z = (sx > sy) ? mask : 0;
        "clgt": z = (x > y) ? mask : 0;
        default: begin
          z = 0;
          while (z < w && ((x >> (w - 1 - z)) & 1) == 0) z++;
        end
      endcase
      r = r | (128'(z) << (e * w));
    end
    return r;
  endfunction

  task automatic kill_from(input int e);
    while (exp_q.size() > 0 && exp_q[$].due >= e) void'(exp_q.pop_back());
  endtask

  task automatic drive(input bit iv, input bit fl, input logic [10:0] opc,
                       input logic [127:0] a, input logic [127:0] b, input logic [9:0] im,
                       input logic [6:0] tag);
    int e; bit lg; logic [127:0] r;
    @(negedge clk);
    reset = 0; issue_valid = iv; flush = fl; opcode = opc;
    ra = a; rb = b; imm10 = im; rt_addr = tag;
    e = ecount + 1;
    if (fl) kill_from(e);
    else if (iv) begin
      r = ref_fx(opc, a, b, im, lg);
      if (lg) exp_q.push_back('{due: e + int'(LAT) - 1, tag: tag, data: r});
      else ill_at[e] = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 11'h0, '0, '0, 10'h0, 7'h0);
  endtask

  task automatic reset_cycles(input int n);
    int e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1; issue_valid = 0; flush = 0;
      e = ecount + 1;
      rst_at[e] = 1;
      kill_from(e);
    end
  endtask

  // Pin the model to a hand-computed value, then issue the same operation to the DUT.
  task automatic op_pin(input string nm, input logic [10:0] opc, input logic [127:0] a,
                        input logic [127:0] b, input logic [9:0] im, input logic [6:0] tag,
                        input logic [127:0] exp);
    bit lg;
    check({"model_", nm}, ref_fx(opc, a, b, im, lg), exp);
    drive(1, 0, opc, a, b, im, tag);
  endtask

  initial begin
    forever begin
      bit           ev;
      logic [127:0] z;
      @(posedge clk);
      #1;
      ev = 0;
      if (rst_at.exists(ecount)) begin
        held_data = '0;
        held_tag  = '0;
      end else if (exp_q.size() > 0 && exp_q[0].due == ecount) begin
        ev        = 1;
        held_data = exp_q[0].data;
        held_tag  = exp_q[0].tag;
        void'(exp_q.pop_front());
      end
      check("wb_valid", {127'b0, wb_valid}, {127'b0, ev});
      check("wb_data", wb_data, held_data);
      check("wb_rt_addr", {121'b0, wb_rt_addr}, {121'b0, held_tag});
      check("illegal_op", {127'b0, illegal_op}, {127'b0, ill_at.exists(ecount)});
`ifndef SPU_FX_FWD_EN
      z = '0;
      check("stage_valid", {126'b0, stage_valid}, z);
      check("stage_rt_addr", {114'b0, stage_rt_addr}, z);
      check("stage_data_nonzero", {127'b0, |stage_data}, z);
`else
      check("stage_valid_last", {127'b0, stage_valid[LAT-1]}, {127'b0, wb_valid});
`endif
    end
  end

  localparam logic [10:0] OpcA  = 11'b00011000000;
  localparam logic [10:0] OpcAh = 11'b00011001000;
  localparam logic [10:0] OpcAi = {8'b00011100, 3'b000};

  initial begin
    logic [10:0] rnd_ops [12];
    reset = 1; issue_valid = 0; flush = 0; opcode = '0;
    ra = '0; rb = '0; imm10 = '0; rt_addr = '0;
    rst_at[1] = 1;
    reset_cycles(2);
    idle(1);
    check("reset_wb_valid", {127'b0, wb_valid}, 128'd0);
    check("reset_wb_data", wb_data, 128'd0);

    op_pin("ah", OpcAh, {8{16'hFFFF}}, {8{16'h0002}}, 10'h0, 7'd9, {8{16'h0001}});
    idle(3);
    op_pin("ai", OpcAi, {4{32'h5}}, '0, 10'h3FF, 7'd10, {4{32'h4}});
    op_pin("sfi", {8'b00001100, 3'b000}, {4{32'h5}}, '0, 10'h3FF, 7'd11, {4{32'hFFFFFFFA}});
    op_pin("cgt", 11'b01001000000, {4{32'hFFFFFFFF}}, {4{32'h1}}, 10'h0, 7'd12, '0);
    op_pin("clgt", 11'b01011000000, {4{32'hFFFFFFFF}}, {4{32'h1}}, 10'h0, 7'd13, '1);
    op_pin("ceq", 11'b01111000000, {4{32'h1234ABCD}}, {4{32'h1234ABCD}}, 10'h0, 7'd14, '1);
    op_pin("clz", 11'b01010100101, {32'h0000FFFF, 32'h80000000, 32'h1, 32'h0}, '0, 10'h0,
           7'd15, {32'd16, 32'd0, 32'd31, 32'd32});
    op_pin("sfh", 11'b00001001000, {8{16'h0003}}, {8{16'h0001}}, 10'h0, 7'd16,
           {8{16'hFFFE}});
    op_pin("cgthi", {8'b01001101, 3'b101}, {4{16'h0001, 16'hFFFE}}, '0, 10'h3FF, 7'd17,
           {4{16'hFFFF, 16'h0000}});
    idle(3);

    // Same destination twice, back to back: both write back in order.
    drive(1, 0, OpcA, {4{32'h1}}, {4{32'h2}}, 10'h0, 7'd20);
    drive(1, 0, OpcA, {4{32'h3}}, {4{32'h4}}, 10'h0, 7'd20);
    idle(3);

    // Four back-to-back issues; flush arrives with the second.
    drive(1, 0, OpcA, {4{32'h10}}, {4{32'h1}}, 10'h0, 7'd1);
    drive(1, 1, OpcA, {4{32'h20}}, {4{32'h1}}, 10'h0, 7'd2);
    drive(1, 0, OpcA, {4{32'h30}}, {4{32'h1}}, 10'h0, 7'd3);
    drive(1, 0, OpcA, {4{32'h40}}, {4{32'h1}}, 10'h0, 7'd4);
    idle(3);

    drive(1, 0, 11'h7FF, '1, '1, 10'h0, 7'd5);
    idle(3);
    drive(1, 1, 11'h7FF, '1, '1, 10'h0, 7'd6);
    idle(2);

    // Reset while an operation is in flight: it must never write back.
    drive(1, 0, OpcA, {4{32'h77}}, {4{32'h1}}, 10'h0, 7'd7);
    reset_cycles(1);
    idle(3);

    rnd_ops = '{11'b00011000001, 11'b01011000001, 11'b00001000001, 11'b01011001001,
                11'b01001000001, 11'b00011001001, 11'b00001001001, 11'b01111001000,
                11'b01011001000, {8'b00010101, 3'b0}, {8'b01000100, 3'b0},
                {8'b01111101, 3'b0}};
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, rnd_ops[i], {$urandom, $urandom, $urandom, $urandom},
            (i % 3 == 0) ? {4{32'h0001FFFF}} : {$urandom, $urandom, $urandom, $urandom},
            10'($urandom), 7'(i + 30));
    end
    idle(int'(LAT) + 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
